ssd_scan_driver: RTL and testbench
==================================

Name: ssd_scan_driver

Overview:
Parametrised multi-digit seven-segment driver for the board display path. It takes a binary value, converts it to BCD with a sequential double-dabble engine, and time-multiplexes NUM_DIGITS digits onto shared active-low cathodes. It adds leading-zero blanking, overflow indication, per-digit decimal points, anti-ghosting dead time and a single-entry pending load buffer. It replaces ad-hoc per-design SSD scan logic (score and position readouts).

Parameters:
NUM_DIGITS, 4, number of digits/anodes driven (≥1, any value, not only powers of two)
BIN_WIDTH, 10, width of binary input value
SCAN_DIV_BITS, 18, each digit slot lasts 2^SCAN_DIV_BITS clk cycles
DEAD_CYCLES, 16, cycles at slot start with all anodes off (< 2^SCAN_DIV_BITS)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
value_in  in  BIN_WIDTH  binary value to display
value_load  in  1  one-cycle strobe; request conversion of value_in
dp_in  in  NUM_DIGITS  decimal-point enables, bit i = digit i, 1 = lit
blank_lz  in  1  1 = suppress leading zeros
enable  in  1  0 = all anodes off; internal counters keep running
busy  out  1  conversion in progress
overflow  out  1  committed value ≥ 10^NUM_DIGITS
anode  out  NUM_DIGITS  active-low one-hot digit select; bit 0 = least significant digit
cathode  out  7  active-low segments {a,b,c,d,e,f,g}
dp  out  1  active-low decimal point

Behaviour:
- Reset (async, reset_n=0): anode all 1, cathode 7'b1111111, dp 1, busy 0, overflow 0. Display digit registers = 0. Pending flag cleared. Scan counter and index = 0. FSM = IDLE.
- Reset mid-conversion aborts it. No commit occurs; the display stays at the reset value.
- Internal digit count INT_DIGITS = max(NUM_DIGITS, (BIN_WIDTH+2)/3). This guarantees that 2^BIN_WIDTH < 10^INT_DIGITS.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on value_load, or if the pending flag is set, latch the source value (the pending value has priority) and clear BCD. Next state SHIFT; busy=1 from the next cycle.
  - SHIFT: exactly BIN_WIDTH cycles. Each cycle adds 3 to every BCD nibble ≥5, then shifts left by 1, bringing in the binary MSB.
  - COMMIT: one cycle. Copy the low NUM_DIGITS nibbles to the display registers atomically. overflow = any higher nibble nonzero. Next state IDLE; busy=0 in the following cycle.
- Latency: value_load sampled at edge t. busy is high for BIN_WIDTH+1 cycles. The display registers update at edge t+BIN_WIDTH+1.
- value_load while busy: value_in is stored in the pending register; the most recent load wins. At most one queued conversion follows the current one, starting the cycle after COMMIT (busy may stay high continuously).
- Scan: a free-running slot counter counts 0..2^SCAN_DIV_BITS-1. On wrap, the digit index increments; it wraps from NUM_DIGITS-1 to 0.
- During the first DEAD_CYCLES cycles of each slot, anode is all 1. Otherwise anode = ~(1<<index) when enable=1, and all 1 when enable=0.
- anode, cathode and dp are registered: one cycle behind the index/counter.
- Digit content per index i:
  - If overflow: DASH (7'b1111110) and dp off.
  - Else if blank_lz=1, i>0, and all digits ≥ i are zero: BLANK (7'b1111111) and dp off.
  - Otherwise the digit code, with dp = ~dp_in[i].
  - Digit 0 is never blanked.
- Digit codes: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- enable toggling does not disturb conversion, scan index or stored values.

Decomposition:
- Shared package ssd_pkg contains:
  - segment constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH
  - FSM state typedef (IDLE/SHIFT/COMMIT)
  - function computing INT_DIGITS
- Sub-module bin2bcd_seq holds the FSM, the pending register and the double-dabble engine. Its ports: clk, reset_n, value_in, value_load, busy, bcd_out, commit pulse.
- ssd_scan_driver instantiates bin2bcd_seq and contains the display registers, scan counter, blanking and output registers.

Test Plan:
1. Assert reset_n=0 mid-scan → anode=1111, cathode=1111111, dp=1, busy=0, overflow=0 immediately (async). After release with enable=1, blank_lz=0 → each digit shows 0000001.
2. Defaults, load 240 → busy high 11 cycles. Digits 3..0 = 0,2,4,0 ("0240"). With blank_lz=1, digit 3 cathode = 1111111 and digit 0 shows 0000001.
3. NUM_DIGITS=2, load 123 → overflow=1, both digits 1111110, dp=1 even with dp_in=11. Then load 7 → overflow=0, digit 0 = 0001111.
4. Load 5, then load 7 and 9 on successive cycles while busy → exactly two commits (5, then 9). busy high continuously for 22 cycles. Final display 9 (0000100).
5. NUM_DIGITS=3, SCAN_DIV_BITS=2, DEAD_CYCLES=1 → anode repeats 111,110,110,110, 111,101,101,101, 111,011,011,011, then wraps to digit 0. enable=0 → anode 111 throughout while index keeps advancing.
6. reset_n pulsed low at SHIFT cycle 5 of a load of 999 → no commit, display stays 0, busy=0. After release, load 42 → "0042" normally.

Source files
------------

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - segment codes, conversion FSM states and internal digit sizing
package ssd_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } bcd_state_e;

  // Enough BCD nibbles that the full binary range never truncates.
  function automatic int int_digits(input int num_digits, input int bin_width);
    int bin_digits;
    bin_digits = (bin_width + 2) / 3;
    return (num_digits > bin_digits) ? num_digits : bin_digits;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// rtl/ssd_scan_driver_if.sv - value load, display control and anode/cathode signal bundle
interface ssd_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 10
);

  logic [BIN_WIDTH-1:0]  value_in;
  logic                  value_load;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  blank_lz;
  logic                  enable;
  logic                  busy;
  logic                  overflow;
  logic [NUM_DIGITS-1:0] anode;
  logic [6:0]            cathode;
  logic                  dp;

  modport master (
    output value_in, value_load, dp_in, blank_lz, enable,
    input  busy, overflow, anode, cathode, dp
  );

  modport slave (
    input  value_in, value_load, dp_in, blank_lz, enable,
    output busy, overflow, anode, cathode, dp
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter with a one-deep pending load
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int BIN_WIDTH  = 10,
  parameter int INT_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [BIN_WIDTH-1:0]    value_in,
  input  logic                    value_load,
  output logic                    busy,
  output logic [4*INT_DIGITS-1:0] bcd_out,
  output logic                    commit
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int BCD_W = 4 * INT_DIGITS;

  bcd_state_e           state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BIN_WIDTH-1:0] pend_val_q, pend_val_d;
  logic                 pend_q, pend_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      bcd_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < INT_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    case (state_q)
      SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
          state_d = COMMIT;
        end
        if (value_load) begin
          pend_d     = 1'b1;
          pend_val_d = value_in;
        end
      end
      default: begin
        // COMMIT may launch the queued value directly so busy never drops between them.
        state_d = IDLE;
        if (pend_q || value_load) begin
          state_d = SHIFT;
          bcd_d   = '0;
          cnt_d   = '0;
          bin_d   = pend_q ? pend_val_q : value_in;
          pend_d  = pend_q && value_load;
          if (value_load) begin
            pend_val_d = value_in;
          end
        end
      end
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign commit  = (state_q == COMMIT);
  assign bcd_out = bcd_q;

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - multiplexed seven-segment driver with BCD conversion and blanking
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int BIN_WIDTH     = 10,
  parameter int SCAN_DIV_BITS = 18,
  parameter int DEAD_CYCLES   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  ssd_scan_driver_if.slave   bus
);

  localparam int INT_DIGITS = int_digits(NUM_DIGITS, BIN_WIDTH);
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*INT_DIGITS-1:0]     bcd_out;
  logic                        bcd_commit;
  logic                        bcd_busy;
  logic                        ovf_next;

  logic [NUM_DIGITS-1:0][3:0]  disp_q, disp_d;
  logic                        overflow_q, overflow_d;
  logic [SCAN_DIV_BITS-1:0]    slot_q, slot_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_DIGITS-1:0]       anode_q, anode_d;
  logic [6:0]                  cathode_q, cathode_d;
  logic                        dp_q, dp_d;

  logic [NUM_DIGITS-1:0]       zero_from;
  logic                        zero_run;
  logic                        dead;

  bin2bcd_seq #(
    .BIN_WIDTH  (BIN_WIDTH),
    .INT_DIGITS (INT_DIGITS)
  ) u_bcd (
    .clk        (clk),
    .reset_n    (reset_n),
    .value_in   (bus.value_in),
    .value_load (bus.value_load),
    .busy       (bcd_busy),
    .bcd_out    (bcd_out),
    .commit     (bcd_commit)
  );

  generate
    if (INT_DIGITS > NUM_DIGITS) begin : g_ovf
      assign ovf_next = |bcd_out[4*INT_DIGITS-1:4*NUM_DIGITS];
    end else begin : g_no_ovf
      assign ovf_next = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_q     <= '0;
      overflow_q <= 1'b0;
      slot_q     <= '0;
      idx_q      <= '0;
      anode_q    <= '1;
      cathode_q  <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      anode_q    <= anode_d;
      cathode_q  <= cathode_d;
      dp_q       <= dp_d;
    end
  end

  // zero_from[i] is set when digit i and every digit above it are zero.
  always_comb begin
    zero_from = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (disp_q[i] == 4'd0);
      zero_from[i] = zero_run;
    end
  end

  always_comb begin
    disp_d     = disp_q;
    overflow_d = overflow_q;
    if (bcd_commit) begin
      disp_d     = bcd_out[4*NUM_DIGITS-1:0];
      overflow_d = ovf_next;
    end

    slot_d = slot_q + 1'b1;
    idx_d  = idx_q;
    if (slot_q == '1) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    dead    = (slot_q < SCAN_DIV_BITS'(DEAD_CYCLES));
    anode_d = '1;
    if (!dead && bus.enable) begin
      anode_d = ~(NUM_DIGITS'(1) << idx_q);
    end

    cathode_d = seg_encode(disp_q[idx_q]);
    dp_d      = ~bus.dp_in[idx_q];
    if (overflow_q) begin
      cathode_d = SEG_DASH;
      dp_d      = 1'b1;
    end else if (bus.blank_lz && (idx_q != '0) && zero_from[idx_q]) begin
      cathode_d = SEG_BLANK;
      dp_d      = 1'b1;
    end
  end

  assign bus.busy     = bcd_busy;
  assign bus.overflow = overflow_q;
  assign bus.anode    = anode_q;
  assign bus.cathode  = cathode_q;
  assign bus.dp       = dp_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - directed bench for ssd_scan_driver in three configurations
module tb_ssd_scan_driver;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   n_commit_a = 0;

  ssd_scan_driver_if #(.NUM_DIGITS(4), .BIN_WIDTH(10)) bus_a ();
  ssd_scan_driver_if #(.NUM_DIGITS(2), .BIN_WIDTH(10)) bus_b ();
  ssd_scan_driver_if #(.NUM_DIGITS(3), .BIN_WIDTH(10)) bus_c ();

  ssd_scan_driver #(.NUM_DIGITS(4), .BIN_WIDTH(10), .SCAN_DIV_BITS(3), .DEAD_CYCLES(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a));
  ssd_scan_driver #(.NUM_DIGITS(2), .BIN_WIDTH(10), .SCAN_DIV_BITS(3), .DEAD_CYCLES(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b));
  ssd_scan_driver #(.NUM_DIGITS(3), .BIN_WIDTH(10), .SCAN_DIV_BITS(2), .DEAD_CYCLES(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(bus_c));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (dut_a.bcd_commit) n_commit_a <= n_commit_a + 1;

  logic [6:0] a_cath [4];
  logic       a_dp   [4];
  int         a_stamp[4];
  logic [6:0] b_cath [2];
  logic       b_dp   [2];
  int         b_stamp[2];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus_a.anode == ~(4'b0001 << i)) begin
        a_cath[i]  <= bus_a.cathode;
        a_dp[i]    <= bus_a.dp;
        a_stamp[i] <= cyc;
      end
    end
    for (int j = 0; j < 2; j++) begin
      if (bus_b.anode == ~(2'b01 << j)) begin
        b_cath[j]  <= bus_b.cathode;
        b_dp[j]    <= bus_b.dp;
        b_stamp[j] <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Observed word packs {digit refreshed since t0, dp, cathode}.
  task automatic check_dig_a(input string tag, input int i, input logic [6:0] cath, input logic dpv);
    check(tag, {23'd0, a_stamp[i] > t0, a_dp[i], a_cath[i]}, {23'd0, 1'b1, dpv, cath});
  endtask

  task automatic check_dig_b(input string tag, input int i, input logic [6:0] cath, input logic dpv);
    check(tag, {23'd0, b_stamp[i] > t0, b_dp[i], b_cath[i]}, {23'd0, 1'b1, dpv, cath});
  endtask

  task automatic settle_scan();
    t0 = cyc;
    repeat (40) @(negedge clk);
  endtask

  task automatic load_a(input logic [9:0] v);
    bus_a.value_in   = v;
    bus_a.value_load = 1'b1;
    @(negedge clk);
    bus_a.value_load = 1'b0;
  endtask

  task automatic load_b(input logic [9:0] v);
    bus_b.value_in   = v;
    bus_b.value_load = 1'b1;
    @(negedge clk);
    bus_b.value_load = 1'b0;
  endtask

  task automatic wait_busy(input int which, output int n);
    n = 0;
    while (((which == 0) ? bus_a.busy : bus_b.busy) && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  function automatic logic [2:0] exp_anode_c(input int k);
    int c;
    int d;
    c = (k - 1) % 4;
    d = ((k - 1) / 4) % 3;
    return (c == 0) ? 3'b111 : ~(3'b001 << d);
  endfunction

  logic [2:0] pat_c [14] = '{3'b111, 3'b110, 3'b110, 3'b110, 3'b111, 3'b101, 3'b101,
                             3'b101, 3'b111, 3'b011, 3'b011, 3'b011, 3'b111, 3'b110};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c0;
    clk = 1'b0;
    reset_n = 1'b1;
    bus_a.value_in = '0; bus_a.value_load = 1'b0; bus_a.dp_in = 4'b0010;
    bus_a.blank_lz = 1'b0; bus_a.enable = 1'b1;
    bus_b.value_in = '0; bus_b.value_load = 1'b0; bus_b.dp_in = 2'b11;
    bus_b.blank_lz = 1'b0; bus_b.enable = 1'b1;
    bus_c.value_in = '0; bus_c.value_load = 1'b0; bus_c.dp_in = 3'b000;
    bus_c.blank_lz = 1'b0; bus_c.enable = 1'b1;

    #2 reset_n = 1'b0;
    #1;
    check("rst_anode", bus_a.anode, 4'b1111);
    check("rst_cathode", bus_a.cathode, 7'b1111111);
    check("rst_dp", bus_a.dp, 1'b1);
    check("rst_busy", bus_a.busy, 1'b0);
    check("rst_overflow", bus_a.overflow, 1'b0);
    check("rst_anode_c", bus_c.anode, 3'b111);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Scan pattern of the 3-digit instance, counted from reset release.
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check($sformatf("scan_c_k%0d", k), bus_c.anode, pat_c[k-1]);
    end
    bus_c.enable = 1'b0;
    for (int k = 15; k <= 26; k++) begin
      @(negedge clk);
      check($sformatf("scan_c_off_k%0d", k), bus_c.anode, 3'b111);
    end
    bus_c.enable = 1'b1;
    for (int k = 27; k <= 30; k++) begin
      @(negedge clk);
      check($sformatf("scan_c_on_k%0d", k), bus_c.anode, exp_anode_c(k));
    end

    settle_scan();
    check_dig_a("zero_d0", 0, 7'b0000001, 1'b1);
    check_dig_a("zero_d1", 1, 7'b0000001, 1'b0);
    check_dig_a("zero_d2", 2, 7'b0000001, 1'b1);
    check_dig_a("zero_d3", 3, 7'b0000001, 1'b1);

    load_a(10'd240);
    wait_busy(0, n);
    check("busy_len_240", n, 11);
    check("ovf_240", bus_a.overflow, 1'b0);
    repeat (2) @(negedge clk);
    settle_scan();
    check_dig_a("v240_d0", 0, 7'b0000001, 1'b1);
    check_dig_a("v240_d1", 1, 7'b1001100, 1'b0);
    check_dig_a("v240_d2", 2, 7'b0010010, 1'b1);
    check_dig_a("v240_d3", 3, 7'b0000001, 1'b1);
    bus_a.blank_lz = 1'b1;
    settle_scan();
    check_dig_a("v240_lz_d0", 0, 7'b0000001, 1'b1);
    check_dig_a("v240_lz_d2", 2, 7'b0010010, 1'b1);
    check_dig_a("v240_lz_d3", 3, 7'b1111111, 1'b1);
    bus_a.blank_lz = 1'b0;

    load_b(10'd123);
    wait_busy(1, n);
    check("busy_len_123", n, 11);
    check("ovf_123", bus_b.overflow, 1'b1);
    repeat (2) @(negedge clk);
    settle_scan();
    check_dig_b("v123_d0", 0, 7'b1111110, 1'b1);
    check_dig_b("v123_d1", 1, 7'b1111110, 1'b1);
    load_b(10'd7);
    wait_busy(1, n);
    check("ovf_7", bus_b.overflow, 1'b0);
    repeat (2) @(negedge clk);
    settle_scan();
    check_dig_b("v7_d0", 0, 7'b0001111, 1'b0);
    check_dig_b("v7_d1", 1, 7'b0000001, 1'b0);
    bus_b.blank_lz = 1'b1;
    settle_scan();
    check_dig_b("v7_lz_d1", 1, 7'b1111111, 1'b1);

    c0 = n_commit_a;
    load_a(10'd5);
    load_a(10'd7);
    load_a(10'd9);
    wait_busy(0, n);
    check("busy_len_queued", 2 + n, 22);
    check("commits_queued", n_commit_a - c0, 2);
    repeat (2) @(negedge clk);
    settle_scan();
    check_dig_a("v9_d0", 0, 7'b0000100, 1'b1);
    check_dig_a("v9_d1", 1, 7'b0000001, 1'b0);

    c0 = n_commit_a;
    load_a(10'd999);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_anode", bus_a.anode, 4'b1111);
    check("midrst_cathode", bus_a.cathode, 7'b1111111);
    check("midrst_dp", bus_a.dp, 1'b1);
    check("midrst_busy", bus_a.busy, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("midrst_busy_after", bus_a.busy, 1'b0);
    check("midrst_no_commit", n_commit_a - c0, 0);
    settle_scan();
    check_dig_a("midrst_d0", 0, 7'b0000001, 1'b1);
    check_dig_a("midrst_d2", 2, 7'b0000001, 1'b1);

    load_a(10'd42);
    wait_busy(0, n);
    check("busy_len_42", n, 11);
    repeat (2) @(negedge clk);
    settle_scan();
    check_dig_a("v42_d0", 0, 7'b0010010, 1'b1);
    check_dig_a("v42_d1", 1, 7'b1001100, 1'b0);
    check_dig_a("v42_d2", 2, 7'b0000001, 1'b1);
    check_dig_a("v42_d3", 3, 7'b0000001, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
